// File: rtl/niosii_processor_pb_data_in_if.sv
// Avalon-MM slave bus plus raw push-button inputs and level interrupt for the PB_DATA_IN port.
interface niosii_processor_pb_data_in_if #(
  parameter int WIDTH = 15
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  modport slave (
    input  address, chipselect, write_n, writedata, in_port,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata, in_port,
    input  readdata, irq
  );
endinterface

// File: rtl/niosii_processor_pb_data_in.sv
// Debounced push-button input port with rising-edge capture, IRQ mask and level interrupt.
// Input change reaches DATA DEBOUNCE_CYCLES+2 edges after first sample; reads are 1-cycle registered, never stalled.
module niosii_processor_pb_data_in #(
  parameter int WIDTH           = 15,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                          clk,
  input logic                          reset,
  niosii_processor_pb_data_in_if.slave bus
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sync_prev;
  logic [WIDTH-1:0] r_data_in;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [15:0]      r_cnt;
  logic [31:0]      r_readdata;

  logic             w_stable;
  logic             w_load;
  logic             w_wr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edgecap_nxt;
  logic [31:0]      w_rd_mux;

  assign w_stable = (r_sync2 == r_sync_prev);
  assign w_load   = w_stable && (r_cnt == CNT_MAX);
  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_rise   = w_load ? (r_sync2 & ~r_data_in) : '0;
  assign w_clr    = (w_wr && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;
  // Set wins over a simultaneous write-1-to-clear of the same bit.
  assign w_edgecap_nxt = (r_edgecap & ~w_clr) | w_rise;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_data_in;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_edgecap;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_prev <= '0;
      r_data_in   <= '0;
      r_irqmask   <= '0;
      r_edgecap   <= '0;
      r_cnt       <= '0;
      r_readdata  <= '0;
    end else begin
      r_sync1     <= bus.in_port;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;

      if (!w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_load) begin
        r_data_in <= r_sync2;
      end

      if (w_wr && (bus.address == 2'd2)) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end

      r_edgecap  <= w_edgecap_nxt;
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edgecap & r_irqmask);
endmodule

// File: tb/tb_niosii_processor_pb_data_in.sv
// Directed bench: reads push expected {readdata, irq} into a scoreboard; a monitor pops and compares.
module tb_niosii_processor_pb_data_in;
  logic clk;
  logic reset;
  logic rd_req;
  int   checks;
  int   failures;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  niosii_processor_pb_data_in_if #(.WIDTH(15)) bus_if ();

  niosii_processor_pb_data_in #(
    .WIDTH(15),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: a read issued before this edge is sampled just after it.
  always @(posedge clk) begin
    if (rd_req) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: read observed with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (bus_if.readdata !== mon_e.data) begin
          failures++;
          $display("FAIL %s readdata: got 0x%08h expected 0x%08h", mon_e.name, bus_if.readdata, mon_e.data);
        end
        checks++;
        if (bus_if.irq !== mon_e.irq) begin
          failures++;
          $display("FAIL %s irq: got %0b expected %0b", mon_e.name, bus_if.irq, mon_e.irq);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] ed, input logic ei);
    exp_t e;
    e.name = nm;
    e.data = ed;
    e.irq  = ei;
    sb.push_back(e);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    rd_req            = 1'b1;
    @(posedge clk);
    #1;
    rd_req            = 1'b0;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic wr(input logic cs, input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = cs;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rd_req            = 1'b0;
    reset             = 1'b1;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    bus_if.in_port    = '0;
    @(posedge clk);
    #1;
    // Writes during reset must be ignored.
    wr(1'b1, 2'd2, 32'h0000_FFFF);
    wr(1'b1, 2'd3, 32'h0000_FFFF);
    reset = 1'b0;

    rd("rst_data", 2'd0, 32'h0, 1'b0);
    rd("rst_rsvd", 2'd1, 32'h0, 1'b0);
    rd("rst_mask", 2'd2, 32'h0, 1'b0);
    rd("rst_edge", 2'd3, 32'h0, 1'b0);

    // Two-cycle glitch on bit0 never qualifies.
    bus_if.in_port = 15'h0001;
    idle(2);
    bus_if.in_port = 15'h0000;
    idle(10);
    rd("glitch_data", 2'd0, 32'h0, 1'b0);
    rd("glitch_edge", 2'd3, 32'h0, 1'b0);

    // Exact latency: data_in loads at E+6, visible on a read sampled at E+7.
    bus_if.in_port = 15'h0001;
    idle(6);
    rd("lat_before", 2'd0, 32'h0, 1'b0);
    rd("lat_after", 2'd0, 32'h0000_0001, 1'b0);
    rd("lat_edge", 2'd3, 32'h0000_0001, 1'b0);
    wr(1'b1, 2'd3, 32'h0000_7FFF);
    rd("w1c_all", 2'd3, 32'h0, 1'b0);

    // Mask width truncation, read-only DATA, reserved word, chipselect gating.
    wr(1'b1, 2'd2, 32'hFFFF_FFFF);
    rd("mask_trunc", 2'd2, 32'h0000_7FFF, 1'b0);
    wr(1'b1, 2'd0, 32'h0000_AAAA);
    rd("data_ro", 2'd0, 32'h0000_0001, 1'b0);
    wr(1'b1, 2'd1, 32'hFFFF_FFFF);
    rd("rsvd_zero", 2'd1, 32'h0, 1'b0);
    wr(1'b0, 2'd2, 32'h0000_0000);
    rd("cs_block", 2'd2, 32'h0000_7FFF, 1'b0);

    // Falling edge on bit0 must not capture even with everything unmasked.
    bus_if.in_port = 15'h0000;
    idle(10);
    rd("fall_data", 2'd0, 32'h0, 1'b0);
    rd("fall_edge", 2'd3, 32'h0, 1'b0);

    // Masked rising edge on bit2 raises irq; write-1-to-clear drops it.
    wr(1'b1, 2'd2, 32'h0000_0004);
    bus_if.in_port = 15'h0004;
    idle(10);
    rd("b2_edge", 2'd3, 32'h0000_0004, 1'b1);
    wr(1'b1, 2'd3, 32'h0000_0004);
    rd("b2_clear", 2'd3, 32'h0, 1'b0);

    // Clear landing on the same edge bit2 re-qualifies: set must win.
    bus_if.in_port = 15'h0000;
    idle(10);
    rd("b2_low", 2'd0, 32'h0, 1'b0);
    bus_if.in_port = 15'h0004;
    idle(6);
    wr(1'b1, 2'd3, 32'h0000_0004);
    rd("set_wins", 2'd3, 32'h0000_0004, 1'b1);
    wr(1'b1, 2'd3, 32'h0000_0004);
    rd("set_wins_clr", 2'd3, 32'h0, 1'b0);

    // Reset mid-debounce (cnt=2) abandons the count; re-qualify from scratch.
    bus_if.in_port = 15'h7FFF;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rd("mid_rst_data", 2'd0, 32'h0, 1'b0);
    rd("mid_rst_mask", 2'd2, 32'h0, 1'b0);
    rd("mid_rst_edge", 2'd3, 32'h0, 1'b0);
    idle(3);
    rd("requal_before", 2'd0, 32'h0, 1'b0);
    rd("requal_data", 2'd0, 32'h0000_7FFF, 1'b0);
    rd("requal_edge", 2'd3, 32'h0000_7FFF, 1'b0);
    wr(1'b1, 2'd2, 32'h0000_7FFF);
    rd("requal_irq", 2'd3, 32'h0000_7FFF, 1'b1);

    idle(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
